// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback path (simple_tx, simple_rx, message_checker).
package uart_pkg;

  // Start + 8 data + stop bits on the line.
  localparam int bits_per_byte = 10;

  // Message checker alignment state.
  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } checker_state_t;

endpackage

// File: rtl/message_checker_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             _clock,
  input  logic             _reset_n,
  input  logic             _inc,
  output logic [width-1:0] _q
);

  // Count up on inc, stick at the maximum value.
  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      _q <= '0;
    end else if (_inc && (_q != {width{1'b1}})) begin
      _q <= _q + width'(1);
    end
  end

endmodule

// File: rtl/message_checker.sv
// Far-end sink for the UART loopback: compares the received byte stream with a
// fixed expected message, tracks alignment and counts good messages and errors.
module message_checker
  import uart_pkg::*;
#(
  parameter int                   msg_len      = 6,
  parameter logic [8*msg_len-1:0] msg_image    = 48'h50494E470D0A,
  parameter int                   stall_period = 0,
  parameter int                   timeout_max  = 1023
) (
  input  logic        _clock,
  input  logic        _reset_n,
  input  logic [7:0]  _data,
  input  logic        _source_valid,
  output logic        _sink_ready,
  output logic        _synced,
  output logic        _msg_done,
  output logic        _error,
  output logic [15:0] _good_count,
  output logic [15:0] _error_count
);

  localparam int cw = (msg_len > 1) ? $clog2(msg_len) : 1;
  localparam int iw = $clog2(timeout_max + 1);
  localparam int sw = (stall_period > 1) ? $clog2(stall_period) : 1;

  // Expected message, first byte in the most significant position of msg_image.
  logic [7:0] rom [msg_len];

  for (genvar g = 0; g < msg_len; g++) begin : g_rom
    assign rom[g] = msg_image[8*(msg_len-1-g) +: 8];
  end

  checker_state_t state_q, state_d;
  logic [cw-1:0]  cursor_q, cursor_d;
  logic [iw-1:0]  idle_q, idle_d;
  logic [sw-1:0]  stall_q;
  logic           done_d, err_d;
  logic           stall_now, accept, match, first;

  assign stall_now   = (stall_period != 0) && (stall_q == sw'(stall_period - 1));
  assign _sink_ready = _reset_n && !stall_now;
  assign accept      = _source_valid && _sink_ready;
  assign match       = (_data == rom[cursor_q]);
  assign first       = (_data == rom[0]);
  assign _synced     = (state_q == CHECK);

  // Free-running backpressure phase counter, independent of traffic.
  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      stall_q <= '0;
    end else if (stall_period == 0 || stall_now) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + sw'(1);
    end
  end

  // Alignment, mismatch and mid-message timeout decisions.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    idle_d   = idle_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      HUNT: begin
        idle_d = '0;
        if (accept && first) begin
          state_d  = CHECK;
          cursor_d = cw'(1);
        end
      end
      CHECK: begin
        if (accept) begin
          idle_d = '0;
          if (match) begin
            if (cursor_q == cw'(msg_len - 1)) begin
              done_d   = 1'b1;
              cursor_d = '0;
            end else begin
              cursor_d = cursor_q + cw'(1);
            end
          end else begin
            // A wrong byte may itself be the start of the next message.
            err_d = 1'b1;
            if (first) begin
              cursor_d = cw'(1);
            end else begin
              state_d  = HUNT;
              cursor_d = '0;
            end
          end
        end else if (cursor_q != '0) begin
          // Cursor zero is the inter-message gap and never times out.
          if (idle_q == iw'(timeout_max)) begin
            err_d    = 1'b1;
            state_d  = HUNT;
            cursor_d = '0;
            idle_d   = '0;
          end else begin
            idle_d = idle_q + iw'(1);
          end
        end
      end
      default: begin
        state_d  = HUNT;
        cursor_d = '0;
        idle_d   = '0;
      end
    endcase
  end

  // State, cursor, idle timer and the one-cycle status pulses.
  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      state_q   <= HUNT;
      cursor_q  <= '0;
      idle_q    <= '0;
      _msg_done <= 1'b0;
      _error    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      idle_q    <= idle_d;
      _msg_done <= done_d;
      _error    <= err_d;
    end
  end

  sat_counter #(.width(16)) u_good_count (
    ._clock   (_clock),
    ._reset_n (_reset_n),
    ._inc     (done_d),
    ._q       (_good_count)
  );

  sat_counter #(.width(16)) u_error_count (
    ._clock   (_clock),
    ._reset_n (_reset_n),
    ._inc     (err_d),
    ._q       (_error_count)
  );

endmodule

// File: tb/tb_message_checker.sv
// Directed bench for message_checker: alignment, mismatch, timeout, backpressure, reset.
module tb_message_checker;

  logic        clock;
  logic        reset_n;
  logic [7:0]  data;
  logic        source_valid;
  logic        sink_ready;
  logic        synced;
  logic        msg_done;
  logic        error;
  logic [15:0] good_count;
  logic [15:0] error_count;

  logic [7:0]  data_s;
  logic        source_valid_s;
  logic        sink_ready_s;
  logic        synced_s;
  logic        msg_done_s;
  logic        error_s;
  logic [15:0] good_count_s;
  logic [15:0] error_count_s;

  logic        sat_inc;
  logic [2:0]  sat_q;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] ping [6] = '{8'h50, 8'h49, 8'h4E, 8'h47, 8'h0D, 8'h0A};

  message_checker #(.msg_len(6), .stall_period(0), .timeout_max(8)) dut (
    ._clock        (clock),
    ._reset_n      (reset_n),
    ._data         (data),
    ._source_valid (source_valid),
    ._sink_ready   (sink_ready),
    ._synced       (synced),
    ._msg_done     (msg_done),
    ._error        (error),
    ._good_count   (good_count),
    ._error_count  (error_count)
  );

  message_checker #(.msg_len(6), .stall_period(4), .timeout_max(8)) dut_s (
    ._clock        (clock),
    ._reset_n      (reset_n),
    ._data         (data_s),
    ._source_valid (source_valid_s),
    ._sink_ready   (sink_ready_s),
    ._synced       (synced_s),
    ._msg_done     (msg_done_s),
    ._error        (error_s),
    ._good_count   (good_count_s),
    ._error_count  (error_count_s)
  );

  sat_counter #(.width(3)) u_sat (
    ._clock   (clock),
    ._reset_n (reset_n),
    ._inc     (sat_inc),
    ._q       (sat_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    source_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    source_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("ready_in_reset", {31'd0, sink_ready}, 32'd0);
    tick();
    check("rst_synced", {31'd0, synced}, 32'd0);
    check("rst_good", {16'd0, good_count}, 32'd0);
    check("rst_errcnt", {16'd0, error_count}, 32'd0);
    check("rst_pulses", {30'd0, msg_done, error}, 32'd0);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    int cyc;
    int idx;
    int k;
    int pulses;
    reset_n = 1'b0;
    data = 8'h00;
    source_valid = 1'b0;
    data_s = 8'h00;
    source_valid_s = 1'b0;
    sat_inc = 1'b0;
    tick();

    // Reset with a valid first byte presented: nothing may be accepted.
    data = 8'h50;
    source_valid = 1'b1;
    do_reset();
    source_valid = 1'b0;
    check("ready_after_reset", {31'd0, sink_ready}, 32'd1);

    // 1: three back-to-back correct messages.
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 6; i++) begin
        send(ping[i]);
        check("t1_synced", {31'd0, synced}, 32'd1);
        check("t1_done", {31'd0, msg_done}, (i == 5) ? 32'd1 : 32'd0);
        check("t1_error", {31'd0, error}, 32'd0);
      end
    end
    check("t1_good", {16'd0, good_count}, 32'd3);
    check("t1_errcnt", {16'd0, error_count}, 32'd0);

    // 4b: a long gap after a complete message is not a timeout.
    source_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("gap_no_error", {31'd0, error}, 32'd0);
    end
    check("gap_synced", {31'd0, synced}, 32'd1);
    check("gap_errcnt", {16'd0, error_count}, 32'd0);

    // 2: mismatch at the third byte drops back to HUNT.
    do_reset();
    send(8'h50);
    send(8'h49);
    send(8'h58);
    check("t2_error", {31'd0, error}, 32'd1);
    check("t2_synced", {31'd0, synced}, 32'd0);
    check("t2_errcnt", {16'd0, error_count}, 32'd1);
    send(8'h47);
    check("t2_hunt_silent", {31'd0, error}, 32'd0);
    check("t2_hunt_synced", {31'd0, synced}, 32'd0);
    for (int i = 0; i < 6; i++) send(ping[i]);
    check("t2_done", {31'd0, msg_done}, 32'd1);
    check("t2_good", {16'd0, good_count}, 32'd1);
    check("t2_errcnt2", {16'd0, error_count}, 32'd1);

    // 3: mismatching byte that equals exp[0] restarts the message.
    do_reset();
    send(8'h50);
    send(8'h49);
    send(8'h50);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_synced", {31'd0, synced}, 32'd1);
    for (int i = 1; i < 6; i++) send(ping[i]);
    check("t3_done", {31'd0, msg_done}, 32'd1);
    check("t3_good", {16'd0, good_count}, 32'd1);
    check("t3_errcnt", {16'd0, error_count}, 32'd1);

    // 4: mid-message idle; idle reaches 8 after 8 edges, error fires on the 9th.
    do_reset();
    send(8'h50);
    send(8'h49);
    source_valid = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (error) break;
    end
    check("t4_timeout_cycle", cyc, 32'd9);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_synced", {31'd0, synced}, 32'd0);
    check("t4_errcnt", {16'd0, error_count}, 32'd1);
    tick();
    check("t4_pulse_len", {31'd0, error}, 32'd0);

    // 6: reset for one cycle mid-message clears counts and alignment.
    send(8'h50);
    send(8'h49);
    send(8'h4E);
    check("t6_pre_synced", {31'd0, synced}, 32'd1);
    data = 8'h47;
    source_valid = 1'b1;
    do_reset();
    check("t6_after_synced", {31'd0, synced}, 32'd0);
    for (int i = 0; i < 6; i++) send(ping[i]);
    check("t6_good", {16'd0, good_count}, 32'd1);
    check("t6_errcnt", {16'd0, error_count}, 32'd0);
    source_valid = 1'b0;

    // 5: stall_period=4 with valid held high; ready drops every 4th cycle.
    do_reset();
    check("t5_rst_good", {16'd0, good_count_s}, 32'd0);
    idx = 0;
    k = 0;
    pulses = 0;
    source_valid_s = 1'b1;
    while (idx < 18 && k < 40) begin
      data_s = ping[idx % 6];
      #1;
      check("t5_ready", {31'd0, sink_ready_s}, ((k % 4) == 3) ? 32'd0 : 32'd1);
      if ((k % 4) != 3) idx++;
      tick();
      k++;
      if (msg_done_s) pulses++;
    end
    source_valid_s = 1'b0;
    tick();
    if (msg_done_s) pulses++;
    check("t5_bytes", idx, 32'd18);
    check("t5_pulses", pulses, 32'd3);
    check("t5_good", {16'd0, good_count_s}, 32'd3);
    check("t5_errcnt", {16'd0, error_count_s}, 32'd0);

    // Counter saturation on a narrow instance: 9 increments saturate at 7.
    sat_inc = 1'b1;
    repeat (9) tick();
    check("sat_hold", {29'd0, sat_q}, 32'd7);
    sat_inc = 1'b0;
    tick();
    check("sat_idle", {29'd0, sat_q}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
